// File: rtl/io_gearbox_pkg.sv
// io_gearbox_pkg
//   Shared definitions for the pin gearbox: serializer state encoding,
//   beats-per-word helper and parameter legality checks used at elaboration.
package io_gearbox_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Number of pin beats needed to carry one word of word_w bits.
    function automatic int unsigned beats_per_word(input int unsigned word_w,
                                                   input int unsigned pin_w);
        return word_w / pin_w;
    endfunction

    // A word must be a non-zero whole number of pin beats.
    function automatic bit width_ok(input int unsigned word_w,
                                    input int unsigned pin_w);
        return (pin_w != 0) && (word_w >= pin_w) && ((word_w % pin_w) == 0);
    endfunction

    // FIFO depth must be a power of two, at least 2.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/io_gearbox_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy count.
//   Ports:
//     clk, rst_n (sync, active low), ena (low: all state holds)
//     push/din   : write when not full
//     pop/dout   : dout shows the head entry; pop advances when not empty
//     full/empty : derived from level
//     level      : occupancy, 0..DEPTH
module sync_fifo
    import io_gearbox_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = ena & push & ~full;
    assign do_pop  = ena & pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible once the level says so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/io_gearbox.sv
// io_gearbox
//   Pin interface between the pin/boundary-scan layer and the MAC core.
//   Input side: assembles DATA_W-bit operands from PIN_W-bit beats, LSB first,
//   tracks the beat-0 mode and flags mode changes within a word, and forwards
//   address-reset requests.
//   Output side: buffers RES_W-bit results in a FIFO and serialises them onto
//   the result pins, LSB beat first, back-to-back while results are queued.
//   Ports:
//     clk, rst_n (sync, active low), ena (low: freeze, valids/ready forced 0)
//     pin_data_v_i/mode_i/rst_i/pin_data_i : input beat
//     word_v_o/word_mode_o/word_rst_o/word_o : assembled word to the core
//     res_v_i/res_i/res_ready_o            : core result handshake
//     pin_result_v_o/pin_result_o          : output beat
//     fifo_level_o                         : result FIFO occupancy
//     err_mode_o                           : sticky mode-mismatch flag
module io_gearbox
    import io_gearbox_pkg::*;
#(
    parameter int unsigned PIN_W  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     pin_data_v_i,
    input  logic                     pin_data_mode_i,
    input  logic                     pin_data_rst_i,
    input  logic [PIN_W-1:0]         pin_data_i,
    output logic                     word_v_o,
    output logic                     word_mode_o,
    output logic                     word_rst_o,
    output logic [DATA_W-1:0]        word_o,
    input  logic                     res_v_i,
    input  logic [RES_W-1:0]         res_i,
    output logic                     res_ready_o,
    output logic                     pin_result_v_o,
    output logic [PIN_W-1:0]         pin_result_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     err_mode_o
);

    localparam int unsigned B     = beats_per_word(DATA_W, PIN_W);
    localparam int unsigned RB    = beats_per_word(RES_W, PIN_W);
    localparam int unsigned CNT_W = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned IDX_W = (RB > 1) ? $clog2(RB) : 1;

    if (!width_ok(DATA_W, PIN_W)) begin : g_bad_data_w
        $error("io_gearbox: DATA_W must be a multiple of PIN_W");
    end
    if (!width_ok(RES_W, PIN_W)) begin : g_bad_res_w
        $error("io_gearbox: RES_W must be a multiple of PIN_W");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("io_gearbox: DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic              mode0;
    logic              beat_mode;
    logic              last_beat;
    logic              word_v_q;
    logic              word_rst_q;

    assign last_beat = (beat_cnt == CNT_W'(B - 1));
    // On beat 0 the captured mode is not yet in mode0, so use the pin directly.
    assign beat_mode = (beat_cnt == '0) ? pin_data_mode_i : mode0;

    always_comb begin
        acc_next = acc;
        acc_next[beat_cnt * PIN_W +: PIN_W] = pin_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            acc         <= '0;
            mode0       <= 1'b0;
            word_v_q    <= 1'b0;
            word_rst_q  <= 1'b0;
            word_o      <= '0;
            word_mode_o <= 1'b0;
            err_mode_o  <= 1'b0;
        end else if (!ena) begin
            // Pulses must not replay when ena returns.
            word_v_q   <= 1'b0;
            word_rst_q <= 1'b0;
        end else begin
            word_v_q   <= 1'b0;
            word_rst_q <= pin_data_rst_i;
            if (pin_data_rst_i) begin
                beat_cnt <= '0;
            end else if (pin_data_v_i) begin
                acc <= acc_next;
                if (beat_cnt == '0) begin
                    mode0 <= pin_data_mode_i;
                end else if (pin_data_mode_i != mode0) begin
                    err_mode_o <= 1'b1;
                end
                if (last_beat) begin
                    beat_cnt    <= '0;
                    word_v_q    <= 1'b1;
                    word_o      <= acc_next;
                    word_mode_o <= beat_mode;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign word_v_o   = word_v_q & ena;
    assign word_rst_o = word_rst_q & ena;

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [RES_W-1:0] fifo_dout;

    assign res_ready_o = rst_n & ena & ~fifo_full;
    assign fifo_push   = res_v_i & res_ready_o;

    sync_fifo #(
        .W     (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (res_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    ser_state_t       state;
    ser_state_t       state_next;
    logic [RES_W-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             last_res_beat;

    assign last_res_beat = (idx == IDX_W'(RB - 1));

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        if (ena) begin
            case (state)
                SER_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (last_res_beat) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                        end else begin
                            state_next = SER_IDLE;
                        end
                    end
                end
                default: state_next = SER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (ena) begin
            if (fifo_pop) begin
                shreg <= fifo_dout;
                idx   <= '0;
            end else if ((state == SER_SEND) && !last_res_beat) begin
                shreg <= shreg >> PIN_W;
                idx   <= idx + 1'b1;
            end
        end
    end

    assign pin_result_v_o = (state == SER_SEND) & ena;
    assign pin_result_o   = (state == SER_SEND) ? shreg[PIN_W-1:0] : '0;

endmodule

// File: tb/tb_io_gearbox.sv
module tb_io_gearbox;

    localparam int unsigned PIN_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              pin_data_v_i;
    logic              pin_data_mode_i;
    logic              pin_data_rst_i;
    logic [PIN_W-1:0]  pin_data_i;
    logic              word_v_o;
    logic              word_mode_o;
    logic              word_rst_o;
    logic [DATA_W-1:0] word_o;
    logic              res_v_i;
    logic [RES_W-1:0]  res_i;
    logic              res_ready_o;
    logic              pin_result_v_o;
    logic [PIN_W-1:0]  pin_result_o;
    logic [2:0]        fifo_level_o;
    logic              err_mode_o;

    always #5 clk = ~clk;

    io_gearbox #(
        .PIN_W  (PIN_W),
        .DATA_W (DATA_W),
        .RES_W  (RES_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .pin_data_v_i    (pin_data_v_i),
        .pin_data_mode_i (pin_data_mode_i),
        .pin_data_rst_i  (pin_data_rst_i),
        .pin_data_i      (pin_data_i),
        .word_v_o        (word_v_o),
        .word_mode_o     (word_mode_o),
        .word_rst_o      (word_rst_o),
        .word_o          (word_o),
        .res_v_i         (res_v_i),
        .res_i           (res_i),
        .res_ready_o     (res_ready_o),
        .pin_result_v_o  (pin_result_v_o),
        .pin_result_o    (pin_result_o),
        .fifo_level_o    (fifo_level_o),
        .err_mode_o      (err_mode_o)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        ena;
        logic        v;
        logic        mode;
        logic        rst;
        logic [7:0]  data;
        logic        wv;
        logic        wr;
        logic        wm;
        logic [15:0] word;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t tab [17];

    // Result i carries low byte 0x20+i and high byte 0x10+i.
    function automatic logic [15:0] rval(input int unsigned i);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'h10 + 8'(i);
        lo = 8'h20 + 8'(i);
        return {hi, lo};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] ser_d [5];
        logic       ser_v [5];
        logic [2:0] ser_l [5];
        logic [7:0] fill_d [7];
        logic       fill_v [7];
        logic [2:0] fill_l [7];
        logic       fill_r [7];
        logic [7:0] drain_d [9];
        logic       drain_v [9];
        logic [2:0] drain_l [9];

        //            ena   v     mode  rst   data    wv    wr    wm    word      err   rdy
        tab[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tab[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
        tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
        tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1};
        tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
        tab[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 16'h0201, 1'b0, 1'b1};
        tab[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0, 16'h0201, 1'b0, 1'b1};
        tab[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b1};
        tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b1};
        tab[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b1, 1'b1};
        tab[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b0};
        tab[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b1};
        tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b0};
        tab[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 16'h3322, 1'b1, 1'b1};
        tab[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 16'h3322, 1'b1, 1'b1};
        tab[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1, 16'h6644, 1'b1, 1'b1};

        ser_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ser_d = '{8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h00};
        ser_l = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0};

        fill_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        fill_d = '{8'h00, 8'h20, 8'h10, 8'h21, 8'h11, 8'h22, 8'h12};
        fill_l = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        fill_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        drain_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        drain_d = '{8'h23, 8'h13, 8'h24, 8'h14, 8'h25, 8'h15, 8'h26, 8'h16, 8'h00};
        drain_l = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};

        ena             = 1'b1;
        pin_data_v_i    = 1'b0;
        pin_data_mode_i = 1'b0;
        pin_data_rst_i  = 1'b0;
        pin_data_i      = '0;
        res_v_i         = 1'b0;
        res_i           = '0;
        rst_n           = 1'b0;
        step();
        step();
        check("reset_state",
              {word_v_o, word_mode_o, word_rst_o, word_o, res_ready_o,
               pin_result_v_o, pin_result_o, fifo_level_o, err_mode_o}, 64'h0);
        rst_n = 1'b1;

        // Deserialiser vectors
        for (int i = 0; i < 17; i++) begin
            ena             = tab[i].ena;
            pin_data_v_i    = tab[i].v;
            pin_data_mode_i = tab[i].mode;
            pin_data_rst_i  = tab[i].rst;
            pin_data_i      = tab[i].data;
            step();
            check($sformatf("deser_vec%0d", i),
                  {word_v_o, word_rst_o, word_mode_o, err_mode_o, res_ready_o,
                   pin_result_v_o, word_o},
                  {tab[i].wv, tab[i].wr, tab[i].wm, tab[i].err, tab[i].rdy,
                   1'b0, tab[i].word});
        end
        pin_data_v_i   = 1'b0;
        pin_data_rst_i = 1'b0;
        ena            = 1'b1;
        step();
        check("err_sticky", {63'h0, err_mode_o}, 64'h1);
        rst_n = 1'b0;
        step();
        check("err_cleared_by_reset", {62'h0, err_mode_o, word_v_o}, 64'h0);
        rst_n = 1'b1;
        step();

        // Back-to-back results: beats start 2 cycles after the first push
        res_v_i = 1'b1;
        res_i   = 16'hBEEF;
        step();
        check("ser_first_push",
              {pin_result_v_o, pin_result_o, fifo_level_o}, {1'b0, 8'h00, 3'd1});
        res_i = 16'hCAFE;
        for (int i = 0; i < 5; i++) begin
            step();
            res_v_i = 1'b0;
            check($sformatf("ser_beat%0d", i),
                  {pin_result_v_o, pin_result_o, fifo_level_o},
                  {ser_v[i], ser_d[i], ser_l[i]});
        end

        // ena stall: nothing accepted while disabled
        do_reset();
        ena     = 1'b0;
        res_v_i = 1'b1;
        res_i   = rval(0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_pre%0d", i),
                  {res_ready_o, fifo_level_o, pin_result_v_o}, {1'b0, 3'd0, 1'b0});
        end
        // Fill while serialising until the FIFO is full
        ena = 1'b1;
        for (int i = 0; i < 7; i++) begin
            res_i = rval(i);
            step();
            check($sformatf("fill%0d", i),
                  {pin_result_v_o, pin_result_o, fifo_level_o, res_ready_o},
                  {fill_v[i], fill_d[i], fill_l[i], fill_r[i]});
        end
        // Freeze mid-result with a result still offered
        res_i = rval(7);
        ena   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("freeze%0d", i),
                  {pin_result_v_o, fifo_level_o, res_ready_o}, {1'b0, 3'd4, 1'b0});
        end
        ena     = 1'b1;
        res_v_i = 1'b0;
        #1;
        check("resume_beat",
              {pin_result_v_o, pin_result_o, fifo_level_o, res_ready_o},
              {1'b1, 8'h12, 3'd4, 1'b0});
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("drain%0d", i),
                  {pin_result_v_o, pin_result_o, fifo_level_o, res_ready_o},
                  {drain_v[i], drain_d[i], drain_l[i], 1'b1});
        end

        // Reset during beat 1 of a result
        do_reset();
        res_v_i = 1'b1;
        res_i   = 16'hBEEF;
        step();
        res_i = 16'hCAFE;
        step();
        res_v_i = 1'b0;
        step();
        check("mid_frame_beat1",
              {pin_result_v_o, pin_result_o, fifo_level_o}, {1'b1, 8'hBE, 3'd1});
        rst_n = 1'b0;
        step();
        check("mid_frame_reset",
              {word_v_o, word_mode_o, word_rst_o, word_o, res_ready_o,
               pin_result_v_o, pin_result_o, fifo_level_o, err_mode_o}, 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_reset%0d", i),
                  {pin_result_v_o, fifo_level_o}, {1'b0, 3'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_gearbox.md
# io_gearbox

Parametrised pin-interface block between the chip-level pin/boundary-scan layer and the systolic MAC core, on the core `clk` domain. On the input side it deserialises `DATA_W`-bit operands from `PIN_W`-bit pin beats, and handles mode and address-reset framing. On the output side it buffers `RES_W`-bit core results in a FIFO and serialises them back onto `PIN_W` result pins. This lifts the fixed 8-bit single-beat pin mapping so wider operands and results fit the same pin budget.

## Interface
Parameters:
- `PIN_W`, 8, pin data width per beat.
- `DATA_W`, 16, operand width. Must be a multiple of `PIN_W`. `B = DATA_W/PIN_W` beats per word.
- `RES_W`, 16, result width. Must be a multiple of `PIN_W`. `RB = RES_W/PIN_W` beats per result.
- `DEPTH`, 4, result FIFO depth. Must be ≥2 and a power of two.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: when low, all state holds and all valid/ready outputs are forced to 0.
- `pin_data_v_i` in 1: input beat valid.
- `pin_data_mode_i` in 1: operand mode for this beat.
- `pin_data_rst_i` in 1: address reset / abort.
- `pin_data_i` in `PIN_W`: input beat.
- `word_v_o` out 1: assembled word valid, one-cycle pulse.
- `word_mode_o` out 1: mode of the assembled word.
- `word_rst_o` out 1: address-reset pulse to the core.
- `word_o` out `DATA_W`: assembled word.
- `res_v_i` in 1: core result valid.
- `res_i` in `RES_W`: core result.
- `res_ready_o` out 1: equals `rst_n & ena & (level < DEPTH)`. Does not depend on a same-cycle pop.
- `pin_result_v_o` out 1: output beat valid.
- `pin_result_o` out `PIN_W`: output beat.
- `fifo_level_o` out `$clog2(DEPTH)+1`: FIFO occupancy.
- `err_mode_o` out 1: sticky mode-mismatch flag.

## Operation
- Reset values: every output is 0, the beat counter is 0, the FIFO is empty, the serializer is in IDLE, and `err_mode_o` is 0.
- Deserialiser:
  - Beats are accumulated LSB-first; beat k fills bits `[k*PIN_W +: PIN_W]`.
  - `word_mode_o` is the mode captured on beat 0.
  - On the B-th beat, the counter wraps to 0 and `word_v_o` pulses.
- Mode mismatch: a mode change on any beat k>0 sets `err_mode_o`. The word is still emitted with the beat-0 mode. The flag clears only on reset.
- `pin_data_rst_i` high:
  - Pulses `word_rst_o`, clears the beat counter, and discards partial beats.
  - Takes priority over a same-cycle `pin_data_v_i`; that beat is dropped and no `word_v_o` is produced.
- B=1 is legal: every valid beat produces a word.
- FIFO: a push happens when `res_v_i & res_ready_o`. A result offered while full is not accepted; the core must hold it.
- Serializer FSM:
  - IDLE → SEND when the FIFO is non-empty. This pops one entry into a shift register and clears the beat index.
  - SEND: drives beat index i of the popped result, LSB-first, with `pin_result_v_o` high.
  - After beat RB-1: if the FIFO is non-empty, pop again and stay in SEND with no gap; otherwise go to IDLE.
- Simultaneous push and pop: `level` stays unchanged.
- Reset mid-frame: partial input words and an in-flight result are discarded and the FIFO is flushed.
- `ena` low mid-frame: the beat counter, shift index and FIFO freeze, and resume exactly where they stopped.

## Timing
- `word_v_o`, `word_o`, `word_mode_o` and `word_rst_o` are registered. They assert the cycle after the last beat (or `rst` beat) is sampled.
- A result pushed in cycle t is popped at t+1 if the serializer is IDLE. Its beat 0 appears on the pins at t+2.
- Throughput is one result every RB cycles, with no bubbles while the FIFO is non-empty.
- `fifo_level_o` is registered and updates the cycle after a push or pop.

## Structure
- Shared package `io_gearbox_pkg`:
  - Serializer state encoding (IDLE, SEND).
  - Helper to compute beats-per-word.
  - Elaboration checks for divisibility and DEPTH.
- One sub-module: `sync_fifo` (parameters `W`, `DEPTH`; ports push/pop/full/empty/level). It uses the same `clk`/`rst_n`/`ena` semantics.
- The deserialiser and serializer are inline in `io_gearbox`.

## Test plan
Defaults `PIN_W`=8, `DATA_W`=16, `RES_W`=16, `DEPTH`=4.
- Beats 0x34, then 0x12, mode=1 on both → `word_o`=0x1234 with `word_mode_o`=1, pulsing the cycle after the second beat; `err_mode_o` stays 0.
- Beat 0xAA, then `pin_data_rst_i` together with `pin_data_v_i` on beat 0x55 → `word_rst_o` pulse; no `word_v_o`. Next beats 0x01, 0x02 → word 0x0201.
- Beat 0 with mode=0, beat 1 with mode=1 → word emitted with `word_mode_o`=0 and `err_mode_o`=1, which stays 1 until `rst_n` goes low.
- Push 0xBEEF and 0xCAFE on back-to-back cycles → pin beats 0xEF, 0xBE, 0xFE, 0xCA on four consecutive cycles, starting 2 cycles after the first push.
- Push 5 results while the serializer is stalled by `ena`=0 → `res_ready_o`=0 throughout the stall; after `ena`=1, `fifo_level_o` reaches 4 and `res_ready_o`=0 until the first pop.
- `rst_n` low during beat 1 of a result → all outputs 0 the next cycle, `fifo_level_o`=0, and no further pin beats.
